seg7_digit_sequencer: RTL and testbench

Sequences a multi-digit hex value through the single seven-segment display on `uo_out` inside the Tiny Tapeout wrapper. It accepts a value over a valid/ready load handshake. It shows each digit for a programmable dwell and inserts an inter-digit blank so repeated digits stay distinguishable. All pacing uses an internal clock-enable prescaler rather than a derived clock, so the whole block runs on `clk`.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_decode.sv | 22 ++
 rtl/seg7_digit_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_seg7_digit_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment digit sequencer:
//   - seg7_state_t : sequencer FSM states (IDLE, SHOW, BLANK)
//   - SEG_TABLE    : 16-entry hex-to-segment table, bits 6:0 = g..a, active high
//   - SEG_BLANK    : all segments and dp off
//   - seg7_lookup  : table lookup helper
// ---------------------------------------------------------------------------
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      BLANK = 2'd2
   } seg7_state_t;

   localparam logic [7:0] SEG_BLANK = 8'h00;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
      7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
      7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
      7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
   };

   function automatic logic [6:0] seg7_lookup(input logic [3:0] nibble);
      return SEG_TABLE[nibble];
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Combinational hex nibble to seven-segment pattern decoder.
// Ports:
//   nibble  in  4  hex digit to display
//   dp      in  1  decimal-point enable
//   pattern out 8  bit 7 = dp, bits 6:0 = segments g..a, active high
// ---------------------------------------------------------------------------
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   output logic [7:0] pattern
);

   // Table lookup with the decimal point placed on bit 7
   always_comb begin
      pattern = {dp, seg7_lookup(nibble)};
   end

endmodule

// File: rtl/seg7_digit_sequencer.sv
// ---------------------------------------------------------------------------
// seg7_digit_sequencer
// Shows a DIGITS-digit hex value one digit at a time on a single
// seven-segment display. Each digit is shown for SHOW_TICKS ticks followed by
// BLANK_TICKS ticks of blank, where a tick is TICK_DIV clk cycles produced by
// an internal clock-enable prescaler. Everything runs on clk.
// Ports:
//   clk         in   1           sole clock, rising edge
//   reset       in   1           synchronous active-high reset
//   load_valid  in   1           new value offered
//   load_ready  out  1           idle, value will be accepted
//   load_data   in   4*DIGITS    digit i = [4i+3:4i], digit 0 shown first
//   load_dp     in   DIGITS      decimal-point enable per digit
//   seg_out     out  8           registered {dp, g..a}, active high
//   digit_idx   out  IW          digit currently in SHOW/BLANK
//   busy        out  1           high while in SHOW or BLANK
//   done        out  1           one-cycle pulse when the sequence completes
// ---------------------------------------------------------------------------
module seg7_digit_sequencer
   import seg7_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int TICK_DIV    = 4,
   parameter int SHOW_TICKS  = 3,
   parameter int BLANK_TICKS = 1
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic                                           load_valid,
   output logic                                           load_ready,
   input  logic [4*DIGITS-1:0]                            load_data,
   input  logic [DIGITS-1:0]                              load_dp,
   output logic [7:0]                                     seg_out,
   output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] digit_idx,
   output logic                                           busy,
   output logic                                           done
);

   localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TMAX = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);
   localparam logic [PW-1:0] PRE_MAX    = PW'(TICK_DIV - 1);
   localparam logic [TW-1:0] SHOW_LAST  = TW'(SHOW_TICKS - 1);
   localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_TICKS > 0) ? (BLANK_TICKS - 1) : 0);

   seg7_state_t           state_q, state_d;
   logic [4*DIGITS-1:0]   data_q,  data_d;
   logic [DIGITS-1:0]     dp_q,    dp_d;
   logic [IW-1:0]         idx_q,   idx_d;
   logic [PW-1:0]         pre_q,   pre_d;
   logic [TW-1:0]         tcnt_q,  tcnt_d;
   logic [7:0]            seg_q,   seg_d;
   logic                  busy_q,  busy_d;
   logic                  ready_q, ready_d;
   logic                  done_q,  done_d;

   logic                  accept_s;
   logic                  tick_s;
   logic                  show_end_s;
   logic                  blank_end_s;
   logic                  last_digit_s;
   logic                  step_s;
   logic [IW-1:0]         sel_idx_s;
   logic [4*DIGITS-1:0]   src_data_s;
   logic [DIGITS-1:0]     src_dp_s;
   logic [3:0]            sel_nib_s;
   logic                  sel_dp_s;
   logic [7:0]            dec_pattern_s;

   // Phase timing and handshake qualifiers
   always_comb begin
      accept_s     = load_valid && ready_q;
      tick_s       = (pre_q == PRE_MAX);
      show_end_s   = tick_s && (tcnt_q == SHOW_LAST);
      blank_end_s  = tick_s && (tcnt_q == BLANK_LAST);
      last_digit_s = (idx_q == LAST_IDX);
   end

   // Select the digit whose pattern is loaded next: digit 0 of the incoming
   // value while idle, otherwise the digit after the current one.
   always_comb begin
      src_data_s = (state_q == IDLE) ? load_data : data_q;
      src_dp_s   = (state_q == IDLE) ? load_dp   : dp_q;
      if ((state_q == IDLE) || last_digit_s) begin
         sel_idx_s = '0;
      end else begin
         sel_idx_s = idx_q + IW'(1);
      end
      sel_nib_s = 4'h0;
      sel_dp_s  = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         sel_nib_s = sel_nib_s | (src_data_s[i*4 +: 4] & {4{sel_idx_s == IW'(i)}});
         sel_dp_s  = sel_dp_s  | (src_dp_s[i] & (sel_idx_s == IW'(i)));
      end
   end

   seg7_decode u_decode (
      .nibble  (sel_nib_s),
      .dp      (sel_dp_s),
      .pattern (dec_pattern_s)
   );

   // Next-state, counters and registered-output values
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      dp_d    = dp_q;
      idx_d   = idx_q;
      pre_d   = pre_q;
      tcnt_d  = tcnt_q;
      seg_d   = seg_q;
      done_d  = 1'b0;
      step_s  = 1'b0;

      case (state_q)
         IDLE: begin
            pre_d  = '0;
            tcnt_d = '0;
            idx_d  = '0;
            if (accept_s) begin
               data_d  = load_data;
               dp_d    = load_dp;
               state_d = SHOW;
               seg_d   = dec_pattern_s;
            end else begin
               state_d = IDLE;
               seg_d   = SEG_BLANK;
            end
         end

         SHOW: begin
            pre_d = tick_s ? '0 : (pre_q + PW'(1));
            if (show_end_s) begin
               tcnt_d = '0;
               if (BLANK_TICKS > 0) begin
                  state_d = BLANK;
                  seg_d   = SEG_BLANK;
               end else begin
                  step_s = 1'b1;
               end
            end else if (tick_s) begin
               tcnt_d = tcnt_q + TW'(1);
            end else begin
               tcnt_d = tcnt_q;
            end
         end

         BLANK: begin
            pre_d = tick_s ? '0 : (pre_q + PW'(1));
            if (blank_end_s) begin
               tcnt_d = '0;
               step_s = 1'b1;
            end else if (tick_s) begin
               tcnt_d = tcnt_q + TW'(1);
            end else begin
               tcnt_d = tcnt_q;
            end
         end

         default: begin
            state_d = IDLE;
            idx_d   = '0;
            pre_d   = '0;
            tcnt_d  = '0;
            seg_d   = SEG_BLANK;
         end
      endcase

      // Next-digit step, shared by the end of SHOW (no blank) and end of BLANK
      if (step_s) begin
         if (!last_digit_s) begin
            idx_d   = idx_q + IW'(1);
            state_d = SHOW;
            seg_d   = dec_pattern_s;
         end else begin
            idx_d   = '0;
            state_d = IDLE;
            seg_d   = SEG_BLANK;
            done_d  = 1'b1;
         end
      end else begin
         done_d = 1'b0;
      end

      // Ready returns in the done cycle so back-to-back loads lose no cycles
      busy_d  = (state_d != IDLE);
      ready_d = (state_d == IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         dp_q    <= '0;
         idx_q   <= '0;
         pre_q   <= '0;
         tcnt_q  <= '0;
         seg_q   <= SEG_BLANK;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         dp_q    <= dp_d;
         idx_q   <= idx_d;
         pre_q   <= pre_d;
         tcnt_q  <= tcnt_d;
         seg_q   <= seg_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   assign seg_out    = seg_q;
   assign digit_idx  = idx_q;
   assign busy       = busy_q;
   assign load_ready = ready_q;
   assign done       = done_q;

endmodule

// File: tb/tb_seg7_digit_sequencer.sv
// ---------------------------------------------------------------------------
// tb_seg7_digit_sequencer
// Three sequencer configurations share one stimulus stream:
//   cfg0: DIGITS=4 TICK_DIV=4 SHOW=3 BLANK=1 (defaults)
//   cfg1: DIGITS=4 TICK_DIV=1 SHOW=2 BLANK=0
//   cfg2: DIGITS=1 TICK_DIV=4 SHOW=3 BLANK=1
// On each accepted load a reference model pushes the whole expected per-cycle
// output trace into a queue; a monitor pops one entry per cycle and compares.
// ---------------------------------------------------------------------------
module tb_seg7_digit_sequencer;

   typedef struct {
      logic [7:0] seg;
      logic       busy;
      logic       ready;
      logic       done;
      int         idx;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        load_valid;
   logic [15:0] load_data;
   logic [3:0]  load_dp;
   bit          mon_en;
   int          errors;
   int          checks;

   logic [6:0] tbl [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : cfg
      localparam int D   = (g == 2) ? 1 : 4;
      localparam int TD  = (g == 1) ? 1 : 4;
      localparam int S   = (g == 1) ? 2 : 3;
      localparam int B   = (g == 1) ? 0 : 1;
      localparam int IW  = (D > 1) ? $clog2(D) : 1;
      localparam int PER = (S + B) * TD;

      logic          load_ready;
      logic [7:0]    seg_out;
      logic [IW-1:0] digit_idx;
      logic          busy;
      logic          done;

      exp_t q[$];
      bit   model_ready = 1'b1;

      seg7_digit_sequencer #(
         .DIGITS      (D),
         .TICK_DIV    (TD),
         .SHOW_TICKS  (S),
         .BLANK_TICKS (B)
      ) dut (
         .clk        (clk),
         .reset      (reset),
         .load_valid (load_valid),
         .load_ready (load_ready),
         .load_data  (load_data[4*D-1:0]),
         .load_dp    (load_dp[D-1:0]),
         .seg_out    (seg_out),
         .digit_idx  (digit_idx),
         .busy       (busy),
         .done       (done)
      );

      // Reference model: on accept, queue the full expected trace
      always @(posedge clk) begin
         exp_t          e;
         int            d;
         int            w;
         logic [15:0]   ld;
         logic [3:0]    nib;
         if (reset) begin
            q.delete();
         end else if (load_valid && model_ready) begin
            ld = load_data;
            for (int t = 0; t < D * PER; t++) begin
               d   = t / PER;
               w   = t % PER;
               nib = ld[4*d +: 4];
               if (w < S * TD) e.seg = {load_dp[d], tbl[nib]};
               else            e.seg = 8'h00;
               e.busy  = 1'b1;
               e.ready = 1'b0;
               e.done  = 1'b0;
               e.idx   = d;
               q.push_back(e);
            end
            e.seg = 8'h00; e.busy = 1'b0; e.ready = 1'b1; e.done = 1'b1; e.idx = 0;
            q.push_back(e);
         end
      end

      // Monitor: one expected entry per cycle, idle when the queue is empty
      always @(negedge clk) begin
         exp_t e;
         if (q.size() > 0) begin
            e = q.pop_front();
         end else begin
            e.seg = 8'h00; e.busy = 1'b0; e.ready = 1'b1; e.done = 1'b0; e.idx = 0;
         end
         model_ready = e.ready;
         if (mon_en) begin
            checks = checks + 1;
            if (seg_out !== e.seg || busy !== e.busy || load_ready !== e.ready ||
                done !== e.done || int'(digit_idx) != e.idx) begin
               errors = errors + 1;
               $display("FAIL cfg%0d outputs t=%0t: got seg=%h busy=%b ready=%b done=%b idx=%0d, want seg=%h busy=%b ready=%b done=%b idx=%0d",
                        g, $time, seg_out, busy, load_ready, done, digit_idx,
                        e.seg, e.busy, e.ready, e.done, e.idx);
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [15:0] data, input logic [3:0] dp);
      load_data  = data;
      load_dp    = dp;
      load_valid = 1'b1;
      cycles(1);
      load_valid = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      checks = checks + 1;
      if (cfg[0].seg_out !== 8'h00 || cfg[0].busy !== 1'b0 ||
          cfg[0].load_ready !== 1'b1 || cfg[0].digit_idx !== 2'd0 ||
          cfg[0].done !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL reset state (%s) t=%0t: seg=%h busy=%b ready=%b idx=%0d done=%b",
                  tag, $time, cfg[0].seg_out, cfg[0].busy, cfg[0].load_ready,
                  cfg[0].digit_idx, cfg[0].done);
      end
   endtask

   task automatic wait_done(input int n, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         cycles(1);
         if (cfg[0].done === 1'b1) seen = 1'b1;
      end
      checks = checks + 1;
      if (!seen) begin
         errors = errors + 1;
         $display("FAIL wait expired (%s) t=%0t: no done within %0d cycles", tag, $time, n);
      end
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      mon_en     = 1'b0;
      reset      = 1'b1;
      load_valid = 1'b0;
      load_data  = 16'h0000;
      load_dp    = 4'b0000;
      cycles(1);
      mon_en = 1'b1;
      cycles(3);
      check_reset_state("initial");
      reset = 1'b0;
      cycles(2);

      // Basic sequence
      load(16'h1A8F, 4'b0000);
      wait_done(70, "basic");

      // Decimal point on digit 1
      load(16'h0000, 4'b0010);
      wait_done(70, "dp");

      // Busy rejection: valid held high with changing data
      load_valid = 1'b1;
      for (int i = 0; i < 160; i++) begin
         load_data = 16'($urandom);
         load_dp   = 4'($urandom);
         cycles(1);
      end
      load_valid = 1'b0;
      cycles(70);

      // No-blank pattern (meaningful for cfg1)
      load(16'h3210, 4'b0000);
      cycles(70);

      // Reset during digit 2 SHOW of the default configuration
      load(16'hC5B7, 4'b1001);
      cycles(36);
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      check_reset_state("mid-sequence");
      cycles(3);
      load(16'h9D64, 4'b0100);
      cycles(70);

      // Single-digit edge case (meaningful for cfg2)
      load(16'h000E, 4'b0000);
      cycles(70);

      // Randomized loads with random pulse lengths and gaps
      for (int i = 0; i < 12; i++) begin
         load_data  = 16'($urandom);
         load_dp    = 4'($urandom);
         load_valid = 1'b1;
         cycles($urandom_range(1, 3));
         load_valid = 1'b0;
         cycles($urandom_range(0, 80));
      end
      cycles(70);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
